// File: rtl/conv2d_systolic_stream_pkg.sv
// ---------------------------------------------------------------------------
// conv2d_systolic_stream_pkg : shared FSM states and width helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package conv2d_systolic_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOADW = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Bits needed to index v distinct values (0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv2d_systolic_stream_line_buffer.sv
// ---------------------------------------------------------------------------
// conv2d_systolic_stream_line_buffer : K-1 image rows plus K x K window taps
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module conv2d_systolic_stream_line_buffer
  import conv2d_systolic_stream_pkg::*;
#(
  parameter int DW  = 8,
  parameter int IMG = 4,
  parameter int K   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DW-1:0]     din,
  output logic [K*K*DW-1:0] window
);

  // One raster-ordered delay line: (K-1) full rows plus the K newest pixels.
  // The K newest entries of each row segment are the window columns.
  localparam int LEN = (K - 1) * IMG + K;

  logic [DW-1:0] taps [LEN];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LEN; i++) taps[i] <= '0;
    end else if (en) begin
      taps[0] <= din;
      for (int i = 1; i < LEN; i++) taps[i] <= taps[i-1];
    end
  end

  // taps[0] is the newest pixel, i.e. the bottom-right of the window.
  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign window[(r*K+c)*DW +: DW] = taps[(K-1-r)*IMG + (K-1-c)];
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv2d_systolic_stream.sv
// ---------------------------------------------------------------------------
// conv2d_systolic_stream : streaming K x K valid-window convolution engine
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module conv2d_systolic_stream
  import conv2d_systolic_stream_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG   = 4,
  parameter int K     = 3,
  parameter int ACC_W = 20,
  parameter int OUT_W = 8,
  parameter int SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_start,
  input  logic             w_valid,
  input  logic [DW-1:0]    w_data,
  output logic             w_ready,
  input  logic             sat_mode,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic             done,
  output logic             busy
);

  localparam int NW   = K * K;
  localparam int NRES = (IMG - K + 1) * (IMG - K + 1);
  localparam int PW   = 2 * DW;
  localparam int RC_W = clog2(IMG);
  localparam int WC_W = clog2(NW);
  localparam int RS_W = clog2(NRES + 1);

  state_t state, state_nx;

  logic [RC_W-1:0]    row, col;
  logic [WC_W-1:0]    wcnt;
  logic [RS_W-1:0]    rcnt;
  logic [DW-1:0]      wts [NW];
  logic [K*K*DW-1:0]  window;
  logic [PW-1:0]      prod [NW];
  logic               v1, v2, ovld;
  logic [OUT_W-1:0]   odata, quant;
  logic               sat_q, busy_q;
  logic [ACC_W-1:0]   sum, q;
  logic               pipe_en, first_pix, last_pix, reload, win_ok;
  logic               w_hs, px_hs, o_hs, last_res;

  assign pipe_en   = !ovld || out_ready;
  assign first_pix = (row == '0) && (col == '0);
  assign last_pix  = (row == RC_W'(IMG - 1)) && (col == RC_W'(IMG - 1));
  assign win_ok    = (row >= RC_W'(K - 1)) && (col >= RC_W'(K - 1));
  assign reload    = (state == S_RUN) && w_start && first_pix;
  assign w_hs      = (state == S_LOADW) && w_valid;
  // A reload request between frames wins over a pixel offered in the same cycle.
  assign px_hs     = (state == S_RUN) && pipe_en && in_valid && !reload;
  assign o_hs      = ovld && out_ready;
  assign last_res  = o_hs && (rcnt == RS_W'(NRES - 1));

  // Outputs are forced low for as long as reset is held.
  assign w_ready   = rst && (state == S_LOADW);
  assign in_ready  = rst && (state == S_RUN) && pipe_en && !reload;
  assign out_valid = rst && ovld;
  assign out_data  = rst ? odata : '0;
  assign done      = rst && last_res;
  assign busy      = rst && busy_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  state_nx = S_LOADW;
      S_LOADW: if (w_hs && (wcnt == WC_W'(NW - 1))) state_nx = S_RUN;
      S_RUN: begin
        if (reload)                 state_nx = S_LOADW;
        else if (px_hs && last_pix) state_nx = S_DRAIN;
      end
      S_DRAIN: if (last_res) state_nx = S_RUN;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      row    <= '0;
      col    <= '0;
      wcnt   <= '0;
      rcnt   <= '0;
      sat_q  <= 1'b0;
      busy_q <= 1'b0;
      for (int i = 0; i < NW; i++) wts[i] <= '0;
    end else begin
      state <= state_nx;
      if (w_hs) begin
        wts[wcnt] <= w_data;
        wcnt      <= (wcnt == WC_W'(NW - 1)) ? '0 : wcnt + 1'b1;
      end
      if (px_hs) begin
        if (col == RC_W'(IMG - 1)) begin
          col <= '0;
          row <= (row == RC_W'(IMG - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (first_pix) begin
          sat_q  <= sat_mode;
          busy_q <= 1'b1;
        end
      end
      if (o_hs) rcnt <= last_res ? '0 : rcnt + 1'b1;
      if (last_res) busy_q <= 1'b0;
    end
  end

  conv2d_systolic_stream_line_buffer #(
    .DW  (DW),
    .IMG (IMG),
    .K   (K)
  ) u_line_buffer (
    .clk    (clk),
    .rst    (rst),
    .en     (px_hs),
    .din    (in_data),
    .window (window)
  );

  always_comb begin
    sum = '0;
    for (int i = 0; i < NW; i++) sum = sum + ACC_W'(prod[i]);
  end

  assign q     = sum >> SHIFT;
  assign quant = (sat_q && ((q >> OUT_W) != '0)) ? '1 : q[OUT_W-1:0];

  // Stage 1 is the window shift itself; v1 marks a complete window in it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      ovld  <= 1'b0;
      odata <= '0;
      for (int i = 0; i < NW; i++) prod[i] <= '0;
    end else if (pipe_en) begin
      v1 <= px_hs && win_ok;
      v2 <= v1;
      for (int i = 0; i < NW; i++) prod[i] <= PW'(window[i*DW +: DW]) * PW'(wts[i]);
      ovld  <= v2;
      odata <= quant;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv2d_systolic_stream.sv
// ---------------------------------------------------------------------------
// tb_conv2d_systolic_stream : randomized bench with a behavioural frame model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_conv2d_systolic_stream;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       w_start_s [2], w_valid_s [2], w_ready_s [2], sat_s [2];
  logic       in_valid_s [2], in_ready_s [2], out_valid_s [2], out_ready_s [2];
  logic       done_s [2], busy_s [2];
  logic [7:0] w_data_s [2], in_data_s [2], out_data_s [2];

  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t ce;
  int   rdy_mode [2];
  int   done_cnt [2];
  int   valid_cycles [2];
  bit   hold_pend [2];
  logic [7:0] hold_data [2];
  bit   gaps;

  int w1 [9], wff [9], ones [9], wr [9];
  int px1 [36], pxff [36], ramp [36], pr [36];
  int p16 [16];

  conv2d_systolic_stream #(
    .DW(8), .IMG(4), .K(3), .ACC_W(20), .OUT_W(8), .SHIFT(0)
  ) dut_a (
    .clk(clk), .rst(rst), .w_start(w_start_s[0]), .w_valid(w_valid_s[0]),
    .w_data(w_data_s[0]), .w_ready(w_ready_s[0]), .sat_mode(sat_s[0]),
    .in_valid(in_valid_s[0]), .in_data(in_data_s[0]), .in_ready(in_ready_s[0]),
    .out_valid(out_valid_s[0]), .out_data(out_data_s[0]), .out_ready(out_ready_s[0]),
    .done(done_s[0]), .busy(busy_s[0])
  );

  conv2d_systolic_stream #(
    .DW(8), .IMG(6), .K(3), .ACC_W(20), .OUT_W(8), .SHIFT(2)
  ) dut_b (
    .clk(clk), .rst(rst), .w_start(w_start_s[1]), .w_valid(w_valid_s[1]),
    .w_data(w_data_s[1]), .w_ready(w_ready_s[1]), .sat_mode(sat_s[1]),
    .in_valid(in_valid_s[1]), .in_data(in_data_s[1]), .in_ready(in_ready_s[1]),
    .out_valid(out_valid_s[1]), .out_data(out_data_s[1]), .out_ready(out_ready_s[1]),
    .done(done_s[1]), .busy(busy_s[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void qpush(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic exp_t qpop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Valid-window correlation of one frame, straight from the arithmetic rules.
  task automatic model_frame(input int k, input int img, input int shift, input bit sat,
                             input int w [9], input int px [36]);
    int n, s, qv;
    exp_t e;
    n = img - 2;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += w[i*3+j] * px[(r+i)*img + c + j];
        qv = s >>> shift;
        e.data = sat ? ((qv > 255) ? 255 : qv) : (qv % 256);
        e.last = (r == n - 1) && (c == n - 1);
        qpush(k, e);
      end
    end
  endtask

  // Output compare: every result handshake, stall holds, stray done/valid.
  always @(negedge clk) begin
    if (!rst) begin
      hold_pend[0] = 1'b0;
      hold_pend[1] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (out_valid_s[k]) begin
          valid_cycles[k]++;
          if (hold_pend[k]) check($sformatf("hold_data%0d", k), out_data_s[k], hold_data[k]);
          if (out_ready_s[k]) begin
            hold_pend[k] = 1'b0;
            if (qsize(k) == 0) begin
              check($sformatf("unexpected_out%0d", k), out_valid_s[k], 0);
            end else begin
              ce = qpop(k);
              check($sformatf("out_data%0d", k), out_data_s[k], ce.data);
              check($sformatf("done_on_hs%0d", k), done_s[k], ce.last);
              if (done_s[k]) done_cnt[k]++;
            end
          end else begin
            check($sformatf("stall_in_ready%0d", k), in_ready_s[k], 0);
            hold_pend[k] = 1'b1;
            hold_data[k] = out_data_s[k];
          end
        end else begin
          if (hold_pend[k]) check($sformatf("dropped_valid%0d", k), out_valid_s[k], 1);
          hold_pend[k] = 1'b0;
          if (done_s[k]) check($sformatf("stray_done%0d", k), done_s[k], 0);
        end
      end
    end
  end

  initial begin
    out_ready_s[0] = 1'b1;
    out_ready_s[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        case (rdy_mode[k])
          0:       out_ready_s[k] = 1'b1;
          1:       out_ready_s[k] = ~out_ready_s[k];
          default: out_ready_s[k] = ($urandom_range(0, 3) != 0);
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int k, input bit is_w);
    int t;
    t = 0;
    @(negedge clk);
    while (!(is_w ? w_ready_s[k] : in_ready_s[k])) begin
      t++;
      if (t > 500) begin
        check(is_w ? "w_ready_timeout" : "in_ready_timeout",
              is_w ? w_ready_s[k] : in_ready_s[k], 1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reload(input int k);
    w_start_s[k] = 1'b1;
    tick();
    w_start_s[k] = 1'b0;
  endtask

  task automatic send_weights(input int k, input int w [9]);
    for (int i = 0; i < 9; i++) begin
      w_valid_s[k] = 1'b1;
      w_data_s[k]  = 8'(w[i]);
      wait_hs(k, 1'b1);
      w_valid_s[k] = 1'b0;
      w_data_s[k]  = 8'($urandom);
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic send_pixels(input int k, input int px [36], input bit sat, input int n,
                             input int wstart_at);
    sat_s[k] = sat;
    for (int i = 0; i < n; i++) begin
      in_valid_s[k] = 1'b1;
      in_data_s[k]  = 8'(px[i]);
      w_start_s[k]  = (i == wstart_at);
      w_valid_s[k]  = 1'($urandom_range(0, 1));
      w_data_s[k]   = 8'($urandom);
      wait_hs(k, 1'b0);
      in_valid_s[k] = 1'b0;
      w_start_s[k]  = 1'b0;
      w_valid_s[k]  = 1'b0;
      in_data_s[k]  = 8'($urandom);
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  // Offers junk pixels while the frame drains; none may be taken.
  task automatic wait_frame(input int k);
    int t, d0;
    t  = 0;
    d0 = done_cnt[k];
    check("busy_in_drain", busy_s[k], 1);
    while (qsize(k) != 0 && t < 2000) begin
      in_valid_s[k] = 1'($urandom_range(0, 1));
      in_data_s[k]  = 8'($urandom);
      tick();
      t++;
    end
    in_valid_s[k] = 1'b0;
    check("frame_results_left", qsize(k), 0);
    check("done_pulses", done_cnt[k], d0 + 1);
    check("busy_after_done", busy_s[k], 0);
  endtask

  task automatic run_frame(input int k, input int img, input int shift, input bit sat,
                           input int w [9], input int px [36], input int wstart_at);
    model_frame(k, img, shift, sat, w, px);
    send_pixels(k, px, sat, img * img, wstart_at);
    wait_frame(k);
  endtask

  task automatic chk_zero(input int k);
    check($sformatf("rst_w_ready%0d", k), w_ready_s[k], 0);
    check($sformatf("rst_in_ready%0d", k), in_ready_s[k], 0);
    check($sformatf("rst_out_valid%0d", k), out_valid_s[k], 0);
    check($sformatf("rst_out_data%0d", k), out_data_s[k], 0);
    check($sformatf("rst_done%0d", k), done_s[k], 0);
    check($sformatf("rst_busy%0d", k), busy_s[k], 0);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("w_ready_before_idle_exit", w_ready_s[0], 0);
    tick();
    check("w_ready_after_idle", w_ready_s[0], 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    gaps = 1'b0;
    for (int k = 0; k < 2; k++) begin
      w_start_s[k] = 0; w_valid_s[k] = 0; w_data_s[k] = 0; sat_s[k] = 0;
      in_valid_s[k] = 0; in_data_s[k] = 0; rdy_mode[k] = 0;
      done_cnt[k] = 0; valid_cycles[k] = 0;
    end
    w1  = '{3, 2, 0, 2, 0, 1, 3, 1, 1};
    p16 = '{9, 8, 2, 6, 0, 4, 1, 6, 4, 10, 1, 1, 2, 2, 9, 9};
    for (int i = 0; i < 9; i++) begin
      wff[i]  = 255;
      ones[i] = 1;
    end
    for (int i = 0; i < 36; i++) begin
      px1[i]  = (i < 16) ? p16[i] : 0;
      pxff[i] = (i < 16) ? 255 : 0;
      ramp[i] = i;
    end

    repeat (3) tick();
    @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    release_rst();

    // Reference frame, always-ready sink.
    send_weights(0, w1);
    model_frame(0, 4, 0, 1'b0, w1, px1);
    check("pin_t1_0", q0[0].data, 67);
    check("pin_t1_1", q0[1].data, 74);
    check("pin_t1_2", q0[2].data, 34);
    check("pin_t1_3", q0[3].data, 59);
    begin
      int vc;
      vc = valid_cycles[0];
      send_pixels(0, px1, 1'b0, 16, -1);
      wait_frame(0);
      check("t1_valid_cycles", valid_cycles[0] - vc, 4);
    end

    // Same frame with a toggling sink.
    rdy_mode[0] = 1;
    run_frame(0, 4, 0, 1'b0, w1, px1, -1);
    rdy_mode[0] = 0;

    // Full-scale saturate and wrap.
    reload(0);
    send_weights(0, wff);
    model_frame(0, 4, 0, 1'b1, wff, pxff);
    check("pin_sat", q0[0].data, 255);
    send_pixels(0, pxff, 1'b1, 16, -1);
    wait_frame(0);
    model_frame(0, 4, 0, 1'b0, wff, pxff);
    check("pin_wrap", q0[0].data, 9);
    send_pixels(0, pxff, 1'b0, 16, -1);
    wait_frame(0);

    // Back-to-back frames, kernel kept, w_start mid-frame ignored.
    reload(0);
    send_weights(0, w1);
    rdy_mode[0] = 2;
    gaps = 1'b1;
    run_frame(0, 4, 0, 1'b0, w1, px1, -1);
    run_frame(0, 4, 0, 1'b0, w1, px1, 5);

    // Reset in the middle of a frame, then reload and rerun.
    rdy_mode[0] = 0;
    gaps = 1'b0;
    send_pixels(0, px1, 1'b0, 7, -1);
    rst = 1'b0;
    q0.delete();
    repeat (3) tick();
    @(negedge clk);
    chk_zero(0);
    release_rst();
    send_weights(0, w1);
    run_frame(0, 4, 0, 1'b0, w1, px1, -1);

    // Randomized frames with random kernels and sink back-pressure.
    rdy_mode[0] = 2;
    gaps = 1'b1;
    for (int f = 0; f < 6; f++) begin
      int maxv;
      maxv = ($urandom_range(0, 1) != 0) ? 255 : 15;
      if (f % 2 == 0) begin
        for (int i = 0; i < 9; i++) wr[i] = $urandom_range(0, maxv);
        reload(0);
        send_weights(0, wr);
      end
      for (int i = 0; i < 36; i++) pr[i] = (i < 16) ? $urandom_range(0, maxv) : 0;
      run_frame(0, 4, 0, 1'($urandom_range(0, 1)), wr, pr, -1);
    end

    // Larger image with a result shift.
    gaps = 1'b0;
    send_weights(1, ones);
    model_frame(1, 6, 2, 1'b0, ones, ramp);
    check("pin_ramp_first", q1[0].data, 15);
    check("pin_ramp_last", q1[15].data, 63);
    check("pin_ramp_count", q1.size(), 16);
    send_pixels(1, ramp, 1'b0, 36, -1);
    wait_frame(1);

    rdy_mode[1] = 2;
    gaps = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 9; i++) wr[i] = $urandom_range(0, 255);
      for (int i = 0; i < 36; i++) pr[i] = $urandom_range(0, 255);
      reload(1);
      send_weights(1, wr);
      run_frame(1, 6, 2, 1'($urandom_range(0, 1)), wr, pr, 11);
    end

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
